// File: rtl/stream_eot_fifo.sv
// First-word-fall-through FIFO for streams carrying an end-of-transaction flag per token.
// Flags are registered from next-state occupancy; no bypass when empty, no pass-through when full.
module stream_eot_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_din_eot,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_dout_eot,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_n_q, empty_n_q;
  logic                  wr_acc, rd_acc;

  assign wr_acc = if_write && full_n_q;
  assign rd_acc = if_read  && empty_n_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // full_n stays low through reset so nothing is accepted until the first edge after release
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_n_q  <= (count_d != FULL_CNT);
      empty_n_q <= (count_d != '0);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {if_din_eot, if_din};
  end

  assign if_dout     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign if_dout_eot = mem_q[rd_ptr_q][DATA_WIDTH];
  assign if_empty_n  = empty_n_q;
  assign if_full_n   = full_n_q;
  assign if_count    = count_q;

endmodule
